grid_saver: RTL
===============

# grid_saver

Snapshot engine that copies the live cell grid from the active board RAM into the initialization RAM, so that the current generation becomes the new starting pattern. Its transfer direction is the reverse of the power-up load path. It streams one cell per clock through a synchronous-read RAM of configurable latency, writes each cell on the destination port, counts live cells and raises `finish` when the copy is complete. It sits beside the board RAMs and is triggered by the same toggle-style `start` used elsewhere in the logic.

## Interface
- `P_PARAM_M`, default 5: grid rows.
- `P_PARAM_N`, default 5: grid columns.
- `WIDTH`, default 12: per-axis address width; addresses are `2*WIDTH` bits.
- `READ_LATENCY`, default 1: source RAM read latency in cycles; legal range is 1–4.

Ports (the copy operates on `CELLS = P_PARAM_M*P_PARAM_N`; `CELLS` must be ≤ 2^(2*WIDTH)):
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: toggle trigger; any level change requests a copy.
- `src_addr`  out  2*WIDTH: board RAM read address.
- `src_val`  in  1: board RAM read data, valid `READ_LATENCY` cycles after the address.
- `dst_addr`  out  2*WIDTH: init RAM write address.
- `dst_en`  out  1: init RAM write enable.
- `dst_val`  out  1: init RAM write data.
- `busy`  out  1: a copy is in progress.
- `finish`  out  1: the last copy is complete; held until the next accepted start.
- `live_count`  out  2*WIDTH: number of 1-cells written in the last or current copy.

## Operation
- Reset values: all outputs are 0; the internal `prev_start` is 0; the state is IDLE.
- `prev_start <= start` every cycle in every state.
- A trigger is any edge where `start != prev_start`.
- State machine:
  - IDLE, on trigger → RUN. Set `src_addr<=0`, `finish<=0`, `live_count<=0`, `busy<=1`.
  - RUN: each cycle, present `src_addr` and push `{valid=1, addr}` into the delay line.
    - If `src_addr == CELLS-1`, go to DRAIN and push `valid=0` afterwards.
    - Otherwise increment `src_addr`.
  - DRAIN: push `valid=0` until the delay line is empty and the last write has issued → DONE.
  - DONE, one cycle: `dst_en<=0`, `busy<=0`, `finish<=1` → IDLE.
- Write stage: at any edge where the delay-line output is valid, set `dst_en<=1`, `dst_addr<=` tagged address, `dst_val<=src_val`, and `live_count += src_val`. Otherwise `dst_en<=0`.
- A trigger while `busy` is ignored. It is still consumed via `prev_start`, so the copy is not re-run later.
- `src_addr` holds its last value after RUN. `dst_addr` and `dst_val` hold after the last write.
- Reset asserted mid-copy aborts immediately to the reset values. `finish` stays 0, and the init RAM contents are partially updated; that is acceptable.
- `CELLS == 1`: RUN lasts a single cycle and exactly one write is issued.

## Timing
- Cycle 0 is the first cycle with `busy=1`, with `src_addr=0`.
- The address presented in cycle k is sampled as data at the end of cycle k+L, where L=`READ_LATENCY`. The matching write is visible (`dst_en=1`) in cycle k+L+1.
- Throughput is one cell per cycle. `dst_en` is high for exactly `CELLS` consecutive cycles, from cycle L+1 to cycle `CELLS+L`.
- `finish` rises and `busy` and `dst_en` fall in cycle `CELLS+L+1`.
- From the trigger edge to the first `busy=1` cycle there is 1 cycle.
- `live_count` is final in the same cycle `finish` rises.

## Structure
- Shared package `life_pkg`:
  - state enum `saver_state_t` (IDLE, RUN, DRAIN, DONE);
  - address type `cell_addr_t` (logic [2*WIDTH-1:0]);
  - localparam `CELLS` helper.
- Sub-module `rd_delay_line`:
  - parameterized depth L, carrying `{valid, addr}`;
  - asynchronous reset clears all valid bits;
  - it is reused by other RAM-streaming blocks.

## Test plan
- 3×3 grid, L=1, board pattern 0b101010101 (addr 0 = LSB), one toggle on `start`:
  - 9 writes, addr 0..8, values 1,0,1,0,1,0,1,0,1;
  - `dst_en` high in cycles 2–10;
  - `finish=1` at cycle 11;
  - `live_count=5`.
- Same grid, L=3: first `dst_en` at cycle 4, `finish` at cycle 13, identical data.
- Toggle `start` again at cycle 4 of a copy:
  - exactly 9 writes total;
  - no second copy after `finish`;
  - a later toggle starts a fresh copy with `finish` cleared.
- Assert `rst_n=0` during cycle 5:
  - all outputs are 0 immediately (async);
  - after release, no writes until a new toggle.
- 5×5 all-ones board: 25 writes, `live_count=25`. Then an all-zeros board: `live_count=0`, `finish` re-rises.
- 1×1 grid, L=1: a single write at addr 0 in cycle 2, `finish` in cycle 3.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types for the life board engines: saver FSM states, cell addresses
// and grid-size helpers.
package life_pkg;

    localparam int LIFE_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } saver_state_t;

    typedef logic [2*LIFE_WIDTH-1:0] cell_addr_t;

    function automatic int cells_of(input int rows, input int cols);
        return rows * cols;
    endfunction

    localparam int DEF_CELLS = cells_of(5, 5);

endpackage

// File: rtl/rd_delay_line.sv
// Tags each RAM read with its address and walks it through DEPTH stages so the
// tag lines up with the synchronous-read data.
module rd_delay_line #(
    parameter int DEPTH = 1,
    parameter int AW    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          pending
);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Address tags carry no meaning without their valid bit, so they skip reset.
    always_ff @(posedge clk) begin
        addr_q[0] <= in_addr;
        for (int i = 1; i < DEPTH; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    // Anything still in flight ahead of the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/grid_saver.sv
// Copies the live board RAM into the init RAM one cell per clock, counting live
// cells; kicked off by any level change on the toggle-style start input.
module grid_saver
    import life_pkg::*;
#(
    parameter int P_PARAM_M    = 5,
    parameter int P_PARAM_N    = 5,
    parameter int WIDTH        = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   src_addr,
    input  logic                 src_val,
    output logic [2*WIDTH-1:0]   dst_addr,
    output logic                 dst_en,
    output logic                 dst_val,
    output logic                 busy,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   live_count,
    output saver_state_t         state_dbg
);

    localparam int            AW        = 2 * WIDTH;
    localparam int            CELLS     = cells_of(P_PARAM_M, P_PARAM_N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    // Handshake: a request is any level change on start relative to the value
    // registered last cycle; it is accepted only in IDLE and consumed in every
    // state, so a toggle seen while busy is dropped rather than queued.
    saver_state_t  state;
    logic          prev_start;
    logic          trigger;
    logic          push_valid;
    logic          dl_valid;
    logic [AW-1:0] dl_addr;
    logic          dl_pending;

    assign trigger    = start ^ prev_start;
    assign push_valid = (state == RUN);
    assign state_dbg  = state;

    rd_delay_line #(
        .DEPTH (READ_LATENCY),
        .AW    (AW)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_addr   (src_addr),
        .out_valid (dl_valid),
        .out_addr  (dl_addr),
        .pending   (dl_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_start <= 1'b0;
            src_addr   <= '0;
            dst_addr   <= '0;
            dst_en     <= 1'b0;
            dst_val    <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            live_count <= '0;
        end else begin
            prev_start <= start;

            // Write stage: the tag leaving the delay line matches src_val now.
            if (dl_valid) begin
                dst_en     <= 1'b1;
                dst_addr   <= dl_addr;
                dst_val    <= src_val;
                live_count <= live_count + AW'(src_val);
            end else begin
                dst_en <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state      <= RUN;
                        src_addr   <= '0;
                        finish     <= 1'b0;
                        live_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (src_addr == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        src_addr <= src_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    // Only the output stage may still hold the final tag; it
                    // is written on this same edge.
                    if (!dl_pending) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    dst_en <= 1'b0;
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
